// File: rtl/hilo_pipe_pkg.sv
// Shared HI/LO constants: default data width and default register reset value.
// No logic here; imported by the pipeline top and its stage entry.
package hilo_pipe_pkg;

    localparam int          LENGTH         = 32;
    localparam logic [31:0] INITIAL_VAL_32 = 32'd0;

endpackage

// File: rtl/hilo_stage.sv
// One HI/LO pipeline entry: registered, 1-cycle latency; holds on stall, flush drops control bits.
// Write enables are stored pre-gated by valid so a bubble can never carry a live enable.
module hilo_stage
    import hilo_pipe_pkg::*;
#(
    parameter int               WIDTH     = LENGTH,
    parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(INITIAL_VAL_32)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             flush,
    input  logic             valid_d,
    input  logic             hi_wen_d,
    input  logic             lo_wen_d,
    input  logic [WIDTH-1:0] hi_d,
    input  logic [WIDTH-1:0] lo_d,
    output logic             valid_q,
    output logic             hi_wen_q,
    output logic             lo_wen_q,
    output logic [WIDTH-1:0] hi_q,
    output logic [WIDTH-1:0] lo_q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            hi_wen_q <= 1'b0;
            lo_wen_q <= 1'b0;
            hi_q     <= RESET_VAL;
            lo_q     <= RESET_VAL;
        end else if (flush) begin
            valid_q  <= 1'b0;
            hi_wen_q <= 1'b0;
            lo_wen_q <= 1'b0;
        end else if (!stall) begin
            valid_q  <= valid_d;
            hi_wen_q <= hi_wen_d & valid_d;
            lo_wen_q <= lo_wen_d & valid_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

endmodule

// File: rtl/hilo_pipe.sv
// HI/LO write pipeline with commit and youngest-first read forwarding; STAGES edges input to output.
// stall_in freezes every stage; flush_in kills in-flight entries but never blocks the last-stage commit.
module hilo_pipe
    import hilo_pipe_pkg::*;
#(
    parameter int               WIDTH     = LENGTH,
    parameter int               STAGES    = 3,
    parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(INITIAL_VAL_32)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall_in,
    input  logic             flush_in,
    input  logic             valid_in,
    input  logic             hi_wen_in,
    input  logic             lo_wen_in,
    input  logic [WIDTH-1:0] hi_in,
    input  logic [WIDTH-1:0] lo_in,
    output logic             valid_out,
    output logic             hi_wen_out,
    output logic             lo_wen_out,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic [WIDTH-1:0] hi_q,
    output logic [WIDTH-1:0] lo_q,
    output logic [WIDTH-1:0] hi_rd,
    output logic [WIDTH-1:0] lo_rd
);

    // Chain index 0 is the input slot; index k (1..STAGES) is the output of stage k-1.
    logic [STAGES:0] c_v;
    logic [STAGES:0] c_hw;
    logic [STAGES:0] c_lw;
    logic [WIDTH-1:0] c_h [STAGES+1];
    logic [WIDTH-1:0] c_l [STAGES+1];
    logic            commit;

    assign c_v[0]  = valid_in;
    assign c_hw[0] = hi_wen_in;
    assign c_lw[0] = lo_wen_in;
    assign c_h[0]  = hi_in;
    assign c_l[0]  = lo_in;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        hilo_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .clk      (clk),
            .rst_n    (rst_n),
            .stall    (stall_in),
            .flush    (flush_in),
            .valid_d  (c_v[k]),
            .hi_wen_d (c_hw[k]),
            .lo_wen_d (c_lw[k]),
            .hi_d     (c_h[k]),
            .lo_d     (c_l[k]),
            .valid_q  (c_v[k+1]),
            .hi_wen_q (c_hw[k+1]),
            .lo_wen_q (c_lw[k+1]),
            .hi_q     (c_h[k+1]),
            .lo_q     (c_l[k+1])
        );
    end

    assign valid_out  = c_v[STAGES];
    assign hi_wen_out = c_hw[STAGES];
    assign lo_wen_out = c_lw[STAGES];
    assign hi_out     = c_h[STAGES];
    assign lo_out     = c_l[STAGES];

    assign commit = c_v[STAGES] & (~stall_in | flush_in);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q <= RESET_VAL;
            lo_q <= RESET_VAL;
        end else if (commit) begin
            if (c_hw[STAGES]) hi_q <= c_h[STAGES];
            if (c_lw[STAGES]) lo_q <= c_l[STAGES];
        end
    end

    // Scan oldest to youngest so the youngest matching writer wins.
    always_comb begin
        hi_rd = hi_q;
        lo_rd = lo_q;
        for (int k = STAGES; k >= 1; k--) begin
            if (c_v[k] && c_hw[k]) hi_rd = c_h[k];
            if (c_v[k] && c_lw[k]) lo_rd = c_l[k];
        end
    end

endmodule

// File: doc/hilo_pipe.md
HILO_PIPE -- requirements
Module: hilo_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data width of HI and LO.
REQ-002 SHALL have parameter STAGES, default 3, legal 1..4: in-flight pipeline depth.
REQ-003 SHALL have parameter RESET_VAL, default 0: reset value of every data register.
REQ-004 SHALL have port clk  in  1: single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  in  1: reset, asynchronous assert, active-low.
REQ-006 SHALL have port stall_in  in  1: hold all pipeline stages.
REQ-007 SHALL have port flush_in  in  1: kill all in-flight stages.
REQ-008 SHALL have port valid_in  in  1: the input slot carries an instruction.
REQ-009 SHALL have ports hi_wen_in and lo_wen_in  in  1 each: independent write enables.
REQ-010 SHALL have ports hi_in and lo_in  in  WIDTH each: write data.
REQ-011 SHALL have ports valid_out, hi_wen_out, lo_wen_out  out  1: last-stage control.
REQ-012 SHALL have ports hi_out and lo_out  out  WIDTH: last-stage data.
REQ-013 SHALL have ports hi_q and lo_q  out  WIDTH: committed architectural HI/LO.
REQ-014 SHALL have ports hi_rd and lo_rd  out  WIDTH: forwarded HI/LO read values.

Function
REQ-015 SHALL hold STAGES entries; each entry stores {valid, hi_wen, lo_wen, hi, lo}; stage 0 is youngest.
REQ-016 SHALL advance when stall_in=0 and flush_in=0: stage 0 captures the inputs, and stage k captures stage k-1.
REQ-017 SHALL hold every stage unchanged when stall_in=1 and flush_in=0.
REQ-018 SHALL clear valid, hi_wen and lo_wen in every stage when flush_in=1, regardless of stall_in; data fields need not change.
REQ-019 SHALL gate wen on valid: a stage whose valid=0 has its wen fields treated as 0.
REQ-020 SHALL drive valid_out, hi_wen_out, lo_wen_out, hi_out and lo_out directly from the last stage; latency from input to output is STAGES edges.
REQ-021 SHALL commit the last stage when last.valid=1 and (stall_in=0 or flush_in=1).
- On commit, hi_q<=last.hi if last.hi_wen=1, and lo_q<=last.lo if last.lo_wen=1; each half is independent.
- Consequence: a flush never blocks the commit of the last stage.
REQ-022 SHALL compute hi_rd combinationally as hi of the youngest stage with valid=1 and hi_wen=1; otherwise hi_rd=hi_q. lo_rd follows the same rule using lo_wen.
REQ-023 SHALL reflect a same-edge commit in hi_q/lo_q on the following cycle only; there is no bypass of the inputs into hi_rd/lo_rd.
REQ-024 SHALL treat valid_in=0 with wen=1 as a bubble.

Reset
REQ-025 SHALL, while rst_n=0, set all stage valid/wen bits to 0, all stage data to RESET_VAL, and hi_q/lo_q to RESET_VAL, independent of clk.
REQ-026 SHALL, on rst_n deassertion mid-stream, resume from the empty state; no pre-reset entry commits.
REQ-027 SHALL drive all outputs to reset values during reset: valid_out=0, hi_wen_out=0, lo_wen_out=0, data outputs = RESET_VAL, and hi_rd/lo_rd = RESET_VAL.

Structure
REQ-028 SHALL take the WIDTH default and the RESET_VAL default from the shared header constants (LENGTH and INITIAL_VAL_32).
REQ-029 SHALL instantiate one sub-module, hilo_stage, STAGES times; hilo_stage is a single entry with stall/flush/async reset.
REQ-030 SHALL implement forwarding and commit logic in the top level only.

Verification
REQ-031 Basic latency: STAGES=3; inject hi=0x11, lo=0x22, both wen, valid -> outputs show the entry after 3 edges, and hi_q=0x11, lo_q=0x22 after edge 4.
REQ-032 Split enables: inject hi=0xAA with hi_wen only -> hi_q=0xAA and lo_q is unchanged after commit.
REQ-033 Stall: assert stall_in for 2 cycles with the entry in stage 1 -> the entry stays in place and commit is delayed by exactly 2 cycles.
REQ-034 Flush: entries A (last stage) and B (stage 0), then flush_in=1 -> A commits, B is discarded, and all stages are invalid next cycle.
REQ-035 Forwarding: stage 0 hi=0x5, stage 2 hi=0x7, hi_q=0x1 -> hi_rd=0x5; after flush -> hi_rd equals hi_q.
REQ-036 Reset: assert rst_n=0 asynchronously between edges with the pipe full -> outputs reach RESET_VAL immediately, and nothing commits after release.
